fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Shares the 8-bit, 16-deep FIFO write port between two producers using round-robin arbitration with a per-grant burst limit.
- Gates the consumer's read requests so the FIFO is never read while empty.
- Keeps a shadow occupancy count so no grant is issued that could overflow the FIFO, including writes still in the one-cycle pipeline.
- Sits directly in front of the FIFO instance; fifo_* ports connect one-to-one to the FIFO's wr/rd/din/full/empty.

Parameters:
- DW, 8, data width of producer and FIFO data
- DEPTH, 16, FIFO capacity in words; must match the FIFO instance
- CW, 5, occupancy counter width; must satisfy 2^CW > DEPTH
- BURST, 4, maximum consecutive grants to one owner while the other requester waits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  producer 0 write request; held until granted
- din0  in  DW  producer 0 data; stable while req0=1
- gnt0  out  1  combinational; din0 is accepted in this cycle
- req1  in  1  producer 1 write request
- din1  in  DW  producer 1 data
- gnt1  out  1  combinational; din1 is accepted in this cycle
- rd_req  in  1  consumer read request
- fifo_wr  out  1  registered write strobe to FIFO
- fifo_din  out  DW  registered write data to FIFO
- fifo_rd  out  1  combinational read strobe to FIFO
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- owner  out  2  registered: 0 = idle, 1 = producer 0, 2 = producer 1
- count  out  CW  registered shadow occupancy, 0..DEPTH
- ovf_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=0, count=0, burst counter=0, last-served=1, fifo_wr=0, fifo_din=0, ovf_err=0. gnt0, gnt1 and fifo_rd go to 0 because they are derived from reset state. A write in flight at reset is dropped; the FIFO shares the same reset.
- space = (count + fifo_wr) < DEPTH. No grant is issued when space=0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only req0 → OWN0; only req1 → OWN1.
  - Both → the requester that is not last-served.
  - No grant is issued in the IDLE cycle.
- OWNx, each cycle:
  - gntx = reqx & space.
  - Each grant increments the burst counter.
  - reqx=0 → if the other requester is active, go to OWN(other), else IDLE.
  - Burst counter reaches BURST while the other requester is active → switch to OWN(other), clear burst counter, set last-served=x.
  - Burst counter reaches BURST with the other requester idle → stay in OWNx and clear the burst counter.
  - Any state change clears the burst counter.
- At most one gnt is high per cycle.
- Write latency: a grant in cycle N produces fifo_wr=1 and fifo_din=din of the granted producer in cycle N+1. Back-to-back grants give one write per cycle.
- Reads: fifo_rd = rd_req & (count != 0) & !fifo_empty. fifo_rd is never asserted on an empty FIFO.
- count update:
  - +1 on fifo_wr only; −1 on fifo_rd only.
  - Unchanged when both occur in the same cycle.
  - Saturates at 0 and DEPTH; never wraps.
- ovf_err is set when fifo_wr & fifo_full, or when fifo_rd & fifo_empty. It stays set until reset.
- Full boundary: with count=15 and a write in flight, space=0, so no grant is issued. When a read and an in-flight write occur together, a grant is allowed the next cycle.
- owner reflects the state registered in the same cycle.

Decomposition:
- Package fifo_pkg holds:
  - arbiter state enum {IDLE, OWN0, OWN1}
  - FIFO state enum {EMP, PAR, FUL}, shared with the FIFO and bench decoders
  - DW and DEPTH defaults
- Natural sub-module: rr_pick2. It is a combinational 2-way round-robin selector taking req0, req1 and last-served, and returning the winner.

Test Plan:
- Single producer: req0 held with din0=0xA5 for 1 cycle from IDLE → OWN0; gnt0 in next cycle; fifo_wr=1 with fifo_din=0xA5 one cycle later; count=1.
- Contention: req0 and req1 held continuously, both producers with data → grants alternate in bursts of 4 (0,0,0,0,1,1,1,1,...), first owner is producer 0; owner toggles 1↔2 every 4 grants.
- Fill: req0 held with rd_req=0 → exactly 16 grants; count=16; gnt0 stays 0; fifo_full=1; ovf_err=0.
- Read at full: from count=16, pulse rd_req 1 cycle → fifo_rd=1, count=15, next grant issued; count returns to 16.
- Empty read: rd_req=1 with count=0 → fifo_rd=0, ovf_err=0. Simultaneous write and read at count=5 → count stays 5.
- Reset mid-burst: rst=0 while owner=2 with a write in flight → immediately owner=0, count=0, fifo_wr=0, gnt0=gnt1=0. After release with both requesting, producer 0 is granted first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and anything that
// decodes FIFO status (FIFO instance, benches).
package fifo_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    EMP = 2'd0,
    PAR = 2'd1,
    FUL = 2'd2
  } fifo_state_e;

  function automatic fifo_state_e fifo_state(input logic full, input logic empty);
    if (empty)     return EMP;
    else if (full) return FUL;
    else           return PAR;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on contention the requester not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,   // 0 = producer 0 served last, 1 = producer 1
  output logic valid,
  output logic pick    // 0 = producer 0, 1 = producer 1
);

  assign valid = req0 | req1;
  assign pick  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO write port between two
// producers, with a shadow occupancy count guarding overflow and empty reads.
module fifo_rr_arbiter
  import fifo_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = 5,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  input  logic          rd_req,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_rd,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic [1:0]    owner,
  output logic [CW-1:0] count,
  output logic          ovf_err
);

  localparam int BW = $clog2(BURST + 1);

  arb_state_e    state, state_next;
  logic [BW-1:0] burst_cnt, burst_next, burst_inc;
  logic          last_served, last_next;
  logic          space, reaches;
  logic          own_req, oth_req, own_id;
  arb_state_e    other_state;
  logic          pick_valid, pick;
  logic [CW:0]   occ_pending;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_served),
    .valid (pick_valid),
    .pick  (pick)
  );

  // A write still in the output register already owns a FIFO slot.
  assign occ_pending = {1'b0, count} + (CW + 1)'(fifo_wr);
  assign space       = occ_pending < (CW + 1)'(DEPTH);

  assign gnt0 = (state == OWN0) & req0 & space;
  assign gnt1 = (state == OWN1) & req1 & space;

  assign own_id      = (state == OWN1);
  assign own_req     = own_id ? req1 : req0;
  assign oth_req     = own_id ? req0 : req1;
  assign other_state = own_id ? OWN0 : OWN1;

  assign burst_inc = burst_cnt + BW'(gnt0 | gnt1);
  assign reaches   = (burst_inc == BW'(BURST));

  assign fifo_rd = rd_req & (count != '0) & ~fifo_empty;
  assign owner   = 2'(state);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    last_next  = last_served;
    case (state)
      IDLE: if (pick_valid) state_next = pick ? OWN1 : OWN0;
      OWN0, OWN1: begin
        if (!own_req) begin
          state_next = oth_req ? other_state : IDLE;
        end else if (reaches && oth_req) begin
          state_next = other_state;
          last_next  = own_id;
        end
      end
      default: state_next = IDLE;
    endcase
    burst_next = (state_next != state || reaches) ? '0 : burst_inc;
  end

  // NOTE: state uses non-blocking assignments under an async active-low reset; all of it is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
      fifo_wr     <= 1'b0;
      fifo_din    <= '0;
      count       <= '0;
      ovf_err     <= 1'b0;
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_next;
      last_served <= last_next;
      fifo_wr     <= gnt0 | gnt1;
      if (gnt0)      fifo_din <= din0;
      else if (gnt1) fifo_din <= din1;
      if (fifo_wr && !fifo_rd && count != CW'(DEPTH))
        count <= count + 1'b1;
      else if (fifo_rd && !fifo_wr && count != '0)
        count <= count - 1'b1;
      if ((fifo_wr && fifo_full) || (fifo_rd && fifo_empty))
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a small occupancy model standing in for the FIFO.
module tb_fifo_rr_arbiter;

  localparam int DW = 8, DEPTH = 16, CW = 5, BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, fifo_wr, fifo_rd, ovf_err;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  int            occ;
  int            n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .din0       (din0),
    .gnt0       (gnt0),
    .req1       (req1),
    .din1       (din1),
    .gnt1       (gnt1),
    .rd_req     (rd_req),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_rd    (fifo_rd),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .owner      (owner),
    .count      (count),
    .ovf_err    (ovf_err)
  );

  // Reference FIFO occupancy, sharing the arbiter's reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) occ <= 0;
    else if (fifo_wr && !fifo_rd && occ < DEPTH) occ <= occ + 1;
    else if (fifo_rd && !fifo_wr && occ > 0)     occ <= occ - 1;
  end
  assign fifo_full  = (occ == DEPTH);
  assign fifo_empty = (occ == 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;

    // Reset state
    #12;
    check("rst_owner", owner, 0);
    check("rst_count", count, 0);
    check("rst_wr", fifo_wr, 0);
    check("rst_din", fifo_din, 0);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_ovf", ovf_err, 0);
    step();
    rst = 1'b1;

    // Single producer
    step();
    req0 = 1'b1; din0 = 8'hA5; #1;
    check("idle_no_gnt", gnt0, 0);
    step();
    check("own0", owner, 1);
    check("gnt0_first", gnt0, 1);
    step();
    req0 = 1'b0; #1;
    check("wr_a5", fifo_wr, 1);
    check("din_a5", fifo_din, 8'hA5);
    check("gnt0_drop", gnt0, 0);
    step();
    check("count1", count, 1);
    check("back_idle", owner, 0);
    rd_req = 1'b1; #1;
    check("rd_one", fifo_rd, 1);
    step();
    check("count0", count, 0);
    check("rd_empty_gated", fifo_rd, 0);
    check("ovf_after_empty", ovf_err, 0);

    // Contention: bursts of BURST, producer 0 first
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h10; din1 = 8'h20; #1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step();
      exp_g = (i == 0) ? 2'b00 : ((((i - 1) / BURST) % 2) == 0) ? 2'b01 : 2'b10;
      check($sformatf("contend_gnt_%0d", i), {gnt1, gnt0}, exp_g);
      if (i > 0) check($sformatf("contend_owner_%0d", i), owner, (exp_g == 2'b01) ? 1 : 2);
      if (i == 2) check("contend_din0", fifo_din, 8'h10);
      if (i == 6) check("contend_din1", fifo_din, 8'h20);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();
    rd_req = 1'b0; #1;
    check("drain_count", count, 0);
    check("drain_owner", owner, 0);

    // Fill with a single producer
    req0 = 1'b1; din0 = 8'h3C;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n += int'(gnt0);
    end
    check("fill_grants", n, DEPTH);
    check("fill_count", count, DEPTH);
    check("fill_gnt0", gnt0, 0);
    check("fill_full", fifo_full, 1);
    check("fill_ovf", ovf_err, 0);

    // Read at full, then refill through the full boundary
    rd_req = 1'b1; #1;
    check("full_rd", fifo_rd, 1);
    check("full_no_gnt", gnt0, 0);
    step();
    rd_req = 1'b0; #1;
    check("after_rd_count", count, 15);
    check("after_rd_gnt", gnt0, 1);
    step();
    check("inflight_wr", fifo_wr, 1);
    check("inflight_block", gnt0, 0);
    step();
    check("refull_count", count, DEPTH);

    // Drain to 5, then simultaneous write and read
    req0 = 1'b0; rd_req = 1'b1;
    repeat (11) step();
    rd_req = 1'b0; #1;
    check("count5", count, 5);
    req0 = 1'b1; din0 = 8'h77;
    step();
    check("sim_gnt", gnt0, 1);
    step();
    req0 = 1'b0; rd_req = 1'b1; #1;
    check("sim_wr", fifo_wr, 1);
    check("sim_rd", fifo_rd, 1);
    step();
    rd_req = 1'b0; #1;
    check("sim_count", count, 5);

    // Reset mid-burst with a write in flight
    req1 = 1'b1; din1 = 8'h99;
    step();
    check("own1", owner, 2);
    check("gnt1", gnt1, 1);
    step();
    check("rst_inflight_wr", fifo_wr, 1);
    rst = 1'b0; #1;
    check("mid_rst_owner", owner, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_wr", fifo_wr, 0);
    check("mid_rst_gnt", {gnt1, gnt0}, 0);
    req0 = 1'b1; #1;
    rst = 1'b1;
    step();
    check("post_rst_owner", owner, 1);
    check("post_rst_gnt", {gnt1, gnt0}, 2'b01);
    check("final_ovf", ovf_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
